frame_steer_controller: RTL and testbench

Frame-level scheduler between the per-line orange classifier and the motor/UART command path. It samples the classifier's per-line direction and orangeDetected at each line end, accumulates votes over a frame, and decides one steering command per frame with hysteresis. It issues that command over a valid/ready handshake and drives the classifier's `fast` input.

---
 rtl/steer_pkg.sv | 22 ++
 rtl/vote_counter.sv | 36 +++
 rtl/frame_steer_controller.sv | 192 +++++++++++++++++++
 tb/tb_frame_steer_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_pkg.sv
// Shared direction/command codes and FSM state type for the frame steering controller.
package steer_pkg;

    localparam logic [2:0] DIR_NONE     = 3'b000;
    localparam logic [2:0] DIR_LEFT     = 3'b001;
    localparam logic [2:0] DIR_RIGHT    = 3'b010;
    localparam logic [2:0] DIR_FWD_FAST = 3'b011;
    localparam logic [2:0] DIR_FWD_SLOW = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b000;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        ISSUE  = 2'd3
    } steer_state_t;

    function automatic logic is_fwd(input logic [2:0] code);
        return (code == DIR_FWD_FAST) || (code == DIR_FWD_SLOW);
    endfunction

endpackage

// File: rtl/vote_counter.sv
// Saturating per-frame line vote counter; clear and increment in the same cycle leave it at 1.
module vote_counter #(
    parameter int LINES_MAX = 240,
    parameter int CNT_W     = $clog2(LINES_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end
        if (inc_i && (count_d != CNT_W'(LINES_MAX))) begin
            count_d = count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/frame_steer_controller.sv
// Collects per-line direction votes over a camera frame and issues one hysteresis-filtered
// steering command per frame over a valid/ready handshake (transfer when cmd_valid && cmd_ready).
module frame_steer_controller
    import steer_pkg::*;
#(
    parameter int LINES_MAX      = 240,
    parameter int MIN_VOTES      = 8,
    parameter int CONFIRM_FRAMES = 2,
    parameter int FAST_FRAMES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       VSYNC,
    input  logic       HREF,
    input  logic       orangeDetected,
    input  logic [2:0] direction,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       fast,
    output logic       frame_done,
    output logic [7:0] drop_count,
    output logic [1:0] dbg_state_o
);

    localparam int CNT_W = $clog2(LINES_MAX + 1);
    localparam int TOT_W = CNT_W + 2;
    localparam int CC_W  = $clog2(CONFIRM_FRAMES + 1);
    localparam int FF_W  = $clog2(FAST_FRAMES + 1);

    steer_state_t state_q, state_d;
    logic         href_q, vsync_q;
    logic         line_hit_q, line_hit_d;
    logic [2:0]   line_dir_q, line_dir_d;
    logic [2:0]   cmd_q, cmd_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic [2:0]   cand_q, cand_d;
    logic [CC_W-1:0] cand_cnt_q, cand_cnt_d, cand_cnt_next;
    logic [FF_W-1:0] fwd_frames_q, fwd_frames_d;
    logic [7:0]   drop_q, drop_d;

    logic             line_end, vsync_rise, vote_en, clr_votes, fast_now, issue_ok;
    logic [CNT_W-1:0] left_cnt, right_cnt, fwd_cnt;
    logic [TOT_W-1:0] total;
    logic [2:0]       decision, fwd_code;

    assign line_end   = href_q & ~HREF;
    assign vsync_rise = VSYNC & ~vsync_q;
    assign fast_now   = (fwd_frames_q == FF_W'(FAST_FRAMES));
    // Votes taken while still looking for frame alignment are meaningless.
    assign vote_en    = line_end & line_hit_q & (state_q != SYNC);
    assign clr_votes  = (state_q == DECIDE);

    vote_counter #(.LINES_MAX(LINES_MAX), .CNT_W(CNT_W)) u_left (
        .clk(clk), .reset(reset), .clr_i(clr_votes),
        .inc_i(vote_en && (line_dir_q == DIR_LEFT)), .count_o(left_cnt)
    );
    vote_counter #(.LINES_MAX(LINES_MAX), .CNT_W(CNT_W)) u_right (
        .clk(clk), .reset(reset), .clr_i(clr_votes),
        .inc_i(vote_en && (line_dir_q == DIR_RIGHT)), .count_o(right_cnt)
    );
    vote_counter #(.LINES_MAX(LINES_MAX), .CNT_W(CNT_W)) u_fwd (
        .clk(clk), .reset(reset), .clr_i(clr_votes),
        .inc_i(vote_en && is_fwd(line_dir_q)), .count_o(fwd_cnt)
    );

    always_comb begin
        line_hit_d = line_hit_q;
        line_dir_d = line_dir_q;
        if (line_end) begin
            line_hit_d = 1'b0;
            line_dir_d = DIR_NONE;
        end
        if (HREF && orangeDetected) begin
            line_hit_d = 1'b1;
            line_dir_d = direction;
        end
    end

    // Frame decision; left==right above fwd keeps whatever was last issued.
    always_comb begin
        total    = TOT_W'(left_cnt) + TOT_W'(right_cnt) + TOT_W'(fwd_cnt);
        fwd_code = fast_now ? DIR_FWD_FAST : DIR_FWD_SLOW;
        if (total < TOT_W'(MIN_VOTES)) begin
            decision = CMD_STOP;
        end else if ((fwd_cnt >= left_cnt) && (fwd_cnt >= right_cnt)) begin
            decision = fwd_code;
        end else if (left_cnt > right_cnt) begin
            decision = DIR_LEFT;
        end else if (right_cnt > left_cnt) begin
            decision = DIR_RIGHT;
        end else begin
            decision = cmd_q;
        end
        if (decision != cand_q) begin
            cand_cnt_next = CC_W'(1);
        end else if (cand_cnt_q == CC_W'(CONFIRM_FRAMES)) begin
            cand_cnt_next = cand_cnt_q;
        end else begin
            cand_cnt_next = cand_cnt_q + CC_W'(1);
        end
        issue_ok = (decision != cmd_q) &&
                   ((decision == CMD_STOP) || (cand_cnt_next == CC_W'(CONFIRM_FRAMES)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC:    if (vsync_rise) state_d = ACCUM;
            ACCUM:   if (vsync_rise) state_d = DECIDE;
            DECIDE:  state_d = ((cmd_valid_q && !cmd_ready) || (!cmd_valid_q && issue_ok))
                               ? ISSUE : ACCUM;
            ISSUE: begin
                if (vsync_rise)     state_d = DECIDE;
                else if (cmd_ready) state_d = ACCUM;
            end
            default: state_d = SYNC;
        endcase
    end

    // A decision made while a command is still pending only feeds hysteresis and is counted as dropped.
    always_comb begin
        cmd_d        = cmd_q;
        cmd_valid_d  = cmd_valid_q;
        cand_d       = cand_q;
        cand_cnt_d   = cand_cnt_q;
        fwd_frames_d = fwd_frames_q;
        drop_d       = drop_q;
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (state_q == DECIDE) begin
            cand_d     = decision;
            cand_cnt_d = cand_cnt_next;
            if (cmd_valid_q) begin
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else if (issue_ok) begin
                cmd_d       = decision;
                cmd_valid_d = 1'b1;
            end
            if (is_fwd(cmd_d)) begin
                if (!fast_now) fwd_frames_d = fwd_frames_q + FF_W'(1);
            end else begin
                fwd_frames_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            line_hit_q   <= 1'b0;
            line_dir_q   <= DIR_NONE;
            cmd_q        <= CMD_STOP;
            cmd_valid_q  <= 1'b0;
            cand_q       <= CMD_STOP;
            cand_cnt_q   <= '0;
            fwd_frames_q <= '0;
            drop_q       <= '0;
        end else begin
            href_q       <= HREF;
            vsync_q      <= VSYNC;
            line_hit_q   <= line_hit_d;
            line_dir_q   <= line_dir_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            cand_q       <= cand_d;
            cand_cnt_q   <= cand_cnt_d;
            fwd_frames_q <= fwd_frames_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        cmd_valid   = cmd_valid_q;
        cmd         = cmd_q;
        fast        = fast_now;
        frame_done  = (state_q == DECIDE);
        drop_count  = drop_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_frame_steer_controller.sv
// Randomized frame-level bench for frame_steer_controller with a per-frame vote-tally reference model.
module tb_frame_steer_controller;

    localparam int LINES_MAX   = 240;
    localparam int MIN_VOTES   = 8;
    localparam int CONFIRM     = 2;
    localparam int FAST_FRAMES = 4;

    logic       clk = 1'b0;
    logic       reset, VSYNC, HREF, orangeDetected, cmd_ready;
    logic [2:0] direction;
    logic       cmd_valid, fast, frame_done;
    logic [2:0] cmd;
    logic [7:0] drop_count;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [2:0] exp_q[$];

    bit m_synced, m_pending;
    int m_last, m_cand, m_cand_cnt, m_fwd, m_drops, m_exp_done;
    int none_codes[4] = '{0, 5, 6, 7};

    frame_steer_controller dut (
        .clk(clk), .reset(reset), .VSYNC(VSYNC), .HREF(HREF),
        .orangeDetected(orangeDetected), .direction(direction), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd(cmd), .fast(fast), .frame_done(frame_done),
        .drop_count(drop_count), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: every transfer must match the next expected command; held commands must not move.
    logic [2:0] prev_cmd;
    bit         prev_hold;
    logic [2:0] exp_cmd;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (prev_hold) begin
                n_checks++;
                if (cmd_valid !== 1'b1 || cmd !== prev_cmd)
                    $display("FAIL cmd_hold: valid=%b cmd=%0d, required valid=1 cmd=%0d", cmd_valid, cmd, prev_cmd);
                else n_pass++;
            end
            if (cmd_valid && cmd_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL transfer_unexpected: got cmd=%0d, required no transfer", cmd);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    if (cmd !== exp_cmd) $display("FAIL transfer_cmd: got %0d, required %0d", cmd, exp_cmd);
                    else n_pass++;
                end
            end
            prev_hold = cmd_valid && !cmd_ready;
            prev_cmd  = cmd;
        end
    end

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_synced = 0; m_pending = 0; m_last = 0; m_cand = 0; m_cand_cnt = 0;
        m_fwd = 0; m_drops = 0;
        exp_q.delete();
    endtask

    // One frame's outcome from its vote tally; rdy says whether cmd_ready is high at the frame end.
    task automatic model_frame(input int nl, input int nr, input int nf, input bit rdy);
        int l, r, f, dec;
        bit pend;
        if (!m_synced) begin
            m_synced = 1;
            return;
        end
        m_exp_done++;
        l = sat(nl, LINES_MAX); r = sat(nr, LINES_MAX); f = sat(nf, LINES_MAX);
        pend = m_pending && !rdy;
        if (l + r + f < MIN_VOTES)       dec = 0;
        else if (f >= l && f >= r)       dec = (m_fwd == FAST_FRAMES) ? 3 : 4;
        else if (l > r)                  dec = 1;
        else if (r > l)                  dec = 2;
        else                             dec = m_last;
        if (dec == m_cand) m_cand_cnt = sat(m_cand_cnt + 1, CONFIRM);
        else begin m_cand = dec; m_cand_cnt = 1; end
        if (pend) begin
            m_drops = sat(m_drops + 1, 255);
        end else begin
            m_pending = 0;
            if (dec != m_last && (dec == 0 || m_cand_cnt == CONFIRM)) begin
                m_last = dec;
                exp_q.push_back(3'(dec));
                m_pending = !rdy;
            end
        end
        m_fwd = (m_last == 3 || m_last == 4) ? sat(m_fwd + 1, FAST_FRAMES) : 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // code < 0: a line with no orange pixel; noise direction on non-orange pixels must be ignored.
    task automatic send_line(input int code);
        int hit_px;
        hit_px = $urandom_range(0, 3);
        HREF = 1'b1;
        for (int p = 0; p < 4; p++) begin
            orangeDetected = (code >= 0) && (p == hit_px || $urandom_range(0, 3) == 0);
            direction = orangeDetected ? 3'(code) : 3'($urandom_range(0, 7));
            step();
        end
        HREF = 1'b0;
        orangeDetected = 1'b0;
    endtask

    task automatic line_gap();
        orangeDetected = 1'($urandom_range(0, 1));
        direction = 3'($urandom_range(0, 7));
        step();
        orangeDetected = 1'b0;
        step();
    endtask

    task automatic run_frame(input int nl, input int nr, input int nf, input int nn, input int nmiss,
                             input bit rdy, input bit late_rdy, input bit merge);
        int codes[$];
        int idx, c, fcode;
        fcode = (m_fwd == FAST_FRAMES) ? 3 : 4;
        repeat (nl) codes.push_back(1);
        repeat (nr) codes.push_back(2);
        repeat (nf) codes.push_back(fcode);
        repeat (nn) codes.push_back(none_codes[$urandom_range(0, 3)]);
        repeat (nmiss) codes.push_back(-1);
        cmd_ready = late_rdy ? 1'b0 : rdy;
        while (codes.size() > 0) begin
            idx = $urandom_range(0, codes.size() - 1);
            c = codes[idx];
            codes.delete(idx);
            send_line(c);
            if (codes.size() > 0 || !merge) line_gap();
        end
        model_frame(nl, nr, nf, rdy || late_rdy);
        VSYNC = 1'b1;
        if (late_rdy) cmd_ready = 1'b1;
        step(); step();
        VSYNC = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; VSYNC = 0; HREF = 0; orangeDetected = 0; direction = 0; cmd_ready = 1;
        model_reset();
        repeat (3) step();
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b, required 0", cmd_valid); else n_pass++;
        n_checks++; if (cmd !== 3'd0) $display("FAIL reset_cmd: got %0d, required 0", cmd); else n_pass++;
        n_checks++; if (fast !== 1'b0) $display("FAIL reset_fast: got %b, required 0", fast); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done); else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop_count: got %0d, required 0", drop_count); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_confirm();
        run_frame(0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            run_frame(20, 0, 0, 0, 2, 1, 0, 0);
            n_checks++; if (cmd !== 3'(m_last)) $display("FAIL confirm_cmd[%0d]: got %0d, required %0d", k, cmd, m_last); else n_pass++;
            n_checks++; if (exp_q.size() != 0) $display("FAIL confirm_pending[%0d]: got %0d untransferred, required 0", k, exp_q.size()); else n_pass++;
        end
        n_checks++; if (done_cnt != m_exp_done) $display("FAIL confirm_frame_done: got %0d, required %0d", done_cnt, m_exp_done); else n_pass++;
    endtask

    task automatic test_stop();
        run_frame(5, 0, 0, 1, 3, 1, 0, 0);
        n_checks++; if (cmd !== 3'(m_last)) $display("FAIL stop_cmd: got %0d, required %0d", cmd, m_last); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL stop_pending: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_fast();
        for (int k = 0; k < 8; k++) begin
            run_frame(0, 0, 30, 0, 1, 1, 0, 0);
            n_checks++; if (fast !== (m_fwd == FAST_FRAMES)) $display("FAIL fast[%0d]: got %b, required %b", k, fast, m_fwd == FAST_FRAMES); else n_pass++;
            n_checks++; if (cmd !== 3'(m_last)) $display("FAIL fast_cmd[%0d]: got %0d, required %0d", k, cmd, m_last); else n_pass++;
        end
    endtask

    task automatic test_tie();
        run_frame(0, 20, 0, 0, 0, 1, 0, 0);
        run_frame(0, 20, 0, 0, 0, 1, 0, 1);
        run_frame(10, 10, 0, 0, 2, 1, 0, 0);
        n_checks++; if (cmd !== 3'(m_last)) $display("FAIL tie_cmd: got %0d, required %0d", cmd, m_last); else n_pass++;
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL tie_valid: got %b, required 0", cmd_valid); else n_pass++;
        n_checks++; if (fast !== (m_fwd == FAST_FRAMES)) $display("FAIL tie_fast: got %b, required %b", fast, m_fwd == FAST_FRAMES); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL tie_pending: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_pressure();
        run_frame(20, 0, 0, 0, 0, 0, 0, 0);
        run_frame(20, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            run_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 0, 0, 0);
        n_checks++; if (cmd_valid !== m_pending) $display("FAIL bp_valid: got %b, required %b", cmd_valid, m_pending); else n_pass++;
        n_checks++; if (cmd !== 3'(m_last)) $display("FAIL bp_cmd: got %0d, required %0d", cmd, m_last); else n_pass++;
        n_checks++; if (drop_count !== 8'(m_drops)) $display("FAIL bp_drop_count: got %0d, required %0d", drop_count, m_drops); else n_pass++;
        cmd_ready = 1'b1;
        repeat (3) step();
        m_pending = 0;
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL bp_release_valid: got %b, required 0", cmd_valid); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL bp_release_pending: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_ready_at_vsync();
        run_frame(0, 20, 0, 0, 0, 0, 0, 0);
        run_frame(0, 20, 0, 0, 0, 0, 0, 0);
        run_frame(20, 0, 0, 0, 0, 0, 1, 1);
        run_frame(20, 0, 0, 0, 0, 1, 0, 0);
        n_checks++; if (drop_count !== 8'(m_drops)) $display("FAIL rv_drop_count: got %0d, required %0d", drop_count, m_drops); else n_pass++;
        n_checks++; if (cmd !== 3'(m_last)) $display("FAIL rv_cmd: got %0d, required %0d", cmd, m_last); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rv_pending: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    // Above LINES_MAX both tallies clip to the same value, turning a left majority into a forward tie.
    task automatic test_saturation();
        for (int k = 0; k < 2; k++) begin
            run_frame(245, 0, 241, 0, 0, 1, 0, 0);
            n_checks++; if (cmd !== 3'(m_last)) $display("FAIL sat_cmd[%0d]: got %0d, required %0d", k, cmd, m_last); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL sat_pending: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 15; k++) begin
            run_frame($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            n_checks++; if (cmd !== 3'(m_last)) $display("FAIL rnd_cmd[%0d]: got %0d, required %0d", k, cmd, m_last); else n_pass++;
            n_checks++; if (cmd_valid !== m_pending) $display("FAIL rnd_valid[%0d]: got %b, required %b", k, cmd_valid, m_pending); else n_pass++;
            n_checks++; if (drop_count !== 8'(m_drops)) $display("FAIL rnd_drop[%0d]: got %0d, required %0d", k, drop_count, m_drops); else n_pass++;
            n_checks++; if (fast !== (m_fwd == FAST_FRAMES)) $display("FAIL rnd_fast[%0d]: got %b, required %b", k, fast, m_fwd == FAST_FRAMES); else n_pass++;
            n_checks++; if (done_cnt != m_exp_done) $display("FAIL rnd_done[%0d]: got %0d, required %0d", k, done_cnt, m_exp_done); else n_pass++;
        end
        cmd_ready = 1'b1;
        repeat (3) step();
        m_pending = 0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int done_before;
        cmd_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            send_line(1);
            line_gap();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        n_checks++; if (cmd_valid !== 1'b0 || cmd !== 3'd0) $display("FAIL mid_reset_cmd: got valid=%b cmd=%0d, required 0/0", cmd_valid, cmd); else n_pass++;
        n_checks++; if (fast !== 1'b0 || drop_count !== 8'd0) $display("FAIL mid_reset_flags: got fast=%b drop=%0d, required 0/0", fast, drop_count); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL mid_reset_state: got %0d, required 0", dbg_state); else n_pass++;
        done_before = done_cnt;
        run_frame(20, 0, 0, 0, 0, 1, 0, 0);
        n_checks++; if (done_cnt != done_before) $display("FAIL mid_reset_sync: got %0d frame_done pulses, required 0", done_cnt - done_before); else n_pass++;
        run_frame(20, 0, 0, 0, 0, 1, 0, 0);
        run_frame(20, 0, 0, 0, 0, 1, 0, 0);
        n_checks++; if (done_cnt != done_before + 2) $display("FAIL mid_reset_done: got %0d pulses, required 2", done_cnt - done_before); else n_pass++;
        n_checks++; if (cmd !== 3'(m_last)) $display("FAIL mid_reset_cmd_after: got %0d, required %0d", cmd, m_last); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL mid_reset_pending: got %0d untransferred, required 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        m_exp_done = 0;
        test_reset();
        test_confirm();
        test_stop();
        test_fast();
        test_tie();
        test_back_pressure();
        test_ready_at_vsync();
        test_saturation();
        test_random();
        test_reset_mid_frame();
        repeat (4) step();
        n_checks++; if (done_cnt != m_exp_done) $display("FAIL final_frame_done: got %0d, required %0d", done_cnt, m_exp_done); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
